// File: rtl/eprisc_mem_bridge.sv
// epRISC memory bridge: decodes core word addresses onto the on-chip ROM/RAM,
// sequences their registered read latency plus wait states, and reports completion/faults.
module eprisc_mem_bridge #(
  parameter logic [31:0] ROM_BASE    = 32'h00000000,
  parameter logic [31:0] RAM_BASE    = 32'h00000400,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iRequest,
  input  logic        iWrite,
  input  logic [31:0] iAddr,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oReady,
  output logic        oFault,
  output logic        oBusy,
  output logic [9:0]  oMemAddr,
  output logic [31:0] oMemData,
  output logic        oRAMWrite,
  output logic        oROMEnable,
  input  logic [31:0] iRAMData,
  input  logic [31:0] iROMData
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, stateNext;
  logic [3:0]  waitCnt, waitCntNext;
  logic        memValid, memValidNext;
  logic        isWrite, isWriteNext;
  logic        isRom, isRomNext;
  logic [31:0] dataNext;
  logic        readyNext, faultNext;
  logic [9:0]  memAddrNext;
  logic [31:0] memDataNext;
  logic        ramWriteNext, romEnableNext;
  logic        romHit, ramHit;

  assign romHit = (iAddr[31:10] == ROM_BASE[31:10]);
  assign ramHit = (iAddr[31:10] == RAM_BASE[31:10]);
  assign oBusy  = (state != IDLE);

  always_comb begin
    stateNext     = state;
    waitCntNext   = waitCnt;
    memValidNext  = memValid;
    isWriteNext   = isWrite;
    isRomNext     = isRom;
    dataNext      = oData;
    readyNext     = 1'b0;
    faultNext     = 1'b0;
    memAddrNext   = oMemAddr;
    memDataNext   = oMemData;
    ramWriteNext  = oRAMWrite;
    romEnableNext = oROMEnable;

    case (state)
      IDLE: begin
        if (iRequest) begin
          memAddrNext  = iAddr[9:0];
          memDataNext  = iData;
          isWriteNext  = iWrite;
          isRomNext    = romHit;
          waitCntNext  = WAIT_INIT;
          memValidNext = 1'b0;
          // ROM decode takes priority when both windows overlap
          if (romHit && !iWrite) begin
            romEnableNext = 1'b1;
            stateNext     = ACCESS;
          end else if (romHit || !ramHit) begin
            readyNext = 1'b1;
            faultNext = 1'b1;
            stateNext = DONE;
          end else begin
            ramWriteNext = iWrite;
            stateNext    = ACCESS;
          end
        end
      end

      ACCESS: begin
        ramWriteNext = 1'b0;
        if (waitCnt != 4'd0) begin
          waitCntNext = waitCnt - 4'd1;
        end else if (isWrite || memValid) begin
          if (!isWrite) begin
            dataNext = isRom ? iROMData : iRAMData;
          end
          romEnableNext = 1'b0;
          readyNext     = 1'b1;
          stateNext     = IDLE;
        end else begin
          // memory registers its output on this edge; capture on the next one
          memValidNext = 1'b1;
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state      <= IDLE;
      waitCnt    <= 4'd0;
      memValid   <= 1'b0;
      isWrite    <= 1'b0;
      isRom      <= 1'b0;
      oData      <= 32'd0;
      oReady     <= 1'b0;
      oFault     <= 1'b0;
      oMemAddr   <= 10'd0;
      oMemData   <= 32'd0;
      oRAMWrite  <= 1'b0;
      oROMEnable <= 1'b0;
    end else begin
      state      <= stateNext;
      waitCnt    <= waitCntNext;
      memValid   <= memValidNext;
      isWrite    <= isWriteNext;
      isRom      <= isRomNext;
      oData      <= dataNext;
      oReady     <= readyNext;
      oFault     <= faultNext;
      oMemAddr   <= memAddrNext;
      oMemData   <= memDataNext;
      oRAMWrite  <= ramWriteNext;
      oROMEnable <= romEnableNext;
    end
  end

  // a RAM write strobe never lasts more than one cycle, and faults only qualify completions
  assert property (@(posedge iClk) disable iff (iReset) oRAMWrite |=> !oRAMWrite);
  assert property (@(posedge iClk) disable iff (iReset) oFault |-> oReady);
  assert property (@(posedge iClk) disable iff (iReset) !(oRAMWrite && oROMEnable));

endmodule
